io_bus_responder: RTL

//  Memory-mapped I/O responder on the CPU external bus (ADR/DIN/DOUT/wr_en/rd_en), the slave-side peer of the CPU bus master.

---
 rtl/io_resp_pkg.sv | 34 +++
 rtl/io_resp_fifo.sv | 62 ++++++
 rtl/io_bus_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/io_resp_pkg.sv
// Shared definitions for the io_bus_responder slice: register map, field positions, reset values.
// The IRQ mask fields only take effect when IO_RESP_IRQ_EN is defined.
package io_resp_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_ERR    = 2'd3
  } reg_sel_e;

  // CTRL layout, bit 4 down to bit 0.
  typedef struct packed {
    logic mask_tx_empty;
    logic mask_rx_avail;
    logic tx_flush;
    logic rx_flush;
    logic tx_en;
  } ctrl_t;

  localparam int STATUS_TX_FULL    = 0;
  localparam int STATUS_RX_EMPTY   = 1;
  localparam int STATUS_TX_CNT_LSB = 8;
  localparam int STATUS_RX_CNT_LSB = 16;
  localparam int STATUS_CNT_W      = 8;

  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UDF = 1;
  localparam int ERR_W      = 2;

  localparam ctrl_t             CTRL_RESET = '0;
  localparam logic [ERR_W-1:0]  ERR_RESET  = '0;

endpackage

// File: rtl/io_resp_fifo.sv
// Synchronous FIFO with flush and a fall-through head when empty, so that a
// push and a pop in the same cycle on an empty FIFO hand the pushed word straight to the reader.
module io_resp_fifo #(
  parameter  int DW         = 32,
  parameter  int FIFO_DEPTH = 8,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle, and vice versa.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & (~empty | push);

  assign head = empty ? push_data : mem[rd_ptr];

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by count and pointers alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder on the CPU external bus: 16-byte register window with TX/RX FIFOs.
// Define IO_RESP_IRQ_EN to add the irq output and the CTRL interrupt mask bits.
module io_bus_responder
  import io_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   ADR,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          hit_o,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
`ifdef IO_RESP_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             hit;
  reg_sel_e         sel;
  logic             cpu_wr;
  logic             cpu_rd;
  ctrl_t            ctrl;
  ctrl_t            ctrl_wdata;
  logic [ERR_W-1:0] err;
  logic [ERR_W-1:0] err_evt;
  logic [DW-1:0]    rd_data;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_cnt;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_cnt;
  logic [DW-1:0] rx_head;
  logic          tx_ovf_evt, rx_udf_evt, err_clr;
  logic          unused_bits;

  assign hit = (ADR[31:4] == BASE_ADDR[31:4]);
  assign sel = reg_sel_e'(ADR[3:2]);

  // A simultaneous read and write is treated as a write only.
  assign cpu_wr = wr_en & hit;
  assign cpu_rd = rd_en & ~wr_en & hit;

  assign tx_push  = cpu_wr & (sel == REG_DATA);
  assign tx_valid = ~tx_empty & ctrl.tx_en;
  assign tx_pop   = tx_valid & tx_ready;

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = cpu_rd & (sel == REG_DATA);

  assign tx_ovf_evt = tx_push & tx_full & ~tx_pop;
  assign rx_udf_evt = rx_pop & rx_empty & ~rx_push;
  assign err_evt    = {rx_udf_evt, tx_ovf_evt};
  assign err_clr    = cpu_rd & (sel == REG_ERR);

  assign unused_bits = &{1'b0, ADR[1:0], DIN[DW-1:5]};

  io_resp_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (DIN),
    .pop       (tx_pop),
    .flush     (ctrl.tx_flush),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_cnt)
  );

  io_resp_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .flush     (ctrl.rx_flush),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_cnt)
  );

  always_comb begin
    ctrl_wdata = ctrl_t'(DIN[4:0]);
`ifndef IO_RESP_IRQ_EN
    ctrl_wdata.mask_tx_empty = 1'b0;
    ctrl_wdata.mask_rx_avail = 1'b0;
`endif
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_DATA:   rd_data = rx_udf_evt ? '0 : rx_head;
      REG_STATUS: begin
        rd_data[STATUS_RX_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(rx_cnt);
        rd_data[STATUS_TX_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(tx_cnt);
        rd_data[STATUS_RX_EMPTY]                   = rx_empty;
        rd_data[STATUS_TX_FULL]                    = tx_full;
      end
      REG_CTRL:   rd_data[4:0] = ctrl;
      REG_ERR:    rd_data[ERR_W-1:0] = err;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DOUT  <= '0;
      hit_o <= 1'b0;
    end else if (rd_en && !wr_en) begin
      hit_o <= hit;
      if (hit) DOUT <= rd_data;
    end
  end

  // Flush bits are one-cycle pulses unless rewritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= CTRL_RESET;
    end else if (cpu_wr && sel == REG_CTRL) begin
      ctrl <= ctrl_wdata;
    end else begin
      ctrl.tx_flush <= 1'b0;
      ctrl.rx_flush <= 1'b0;
    end
  end

  // Clear-on-read, but an event in the clearing cycle is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= ERR_RESET;
    else        err <= (err_clr ? '0 : err) | err_evt;
  end

`ifdef IO_RESP_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (ctrl.mask_rx_avail & ~rx_empty)
                     | (ctrl.mask_tx_empty & (tx_cnt == '0))
                     | (|err);
  end
`endif

endmodule
